// File: rtl/altera_input_debouncer.sv
// Synchronizes and debounces an asynchronous input, counts rejected glitches, and recovers safely from illegal state.
// Optional edge pulses (rise_pulse/fall_pulse) are compiled in when ALTERA_DEBOUNCE_EDGE_EN is defined.
module altera_input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    output logic       data_out,
`ifdef ALTERA_DEBOUNCE_EDGE_EN
    output logic       rise_pulse,
    output logic       fall_pulse,
`endif
    output logic [7:0] glitch_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        STABLE_LOW   = 3'd0,
        CONFIRM_HIGH = 3'd1,
        STABLE_HIGH  = 3'd2,
        CONFIRM_LOW  = 3'd3
    } state_e;

    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;

    // Plain vector so the illegal codes 4-7 remain representable and decodable.
    (* syn_encoding = "safe" *) logic [2:0] state_q;
    logic [2:0]             state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   data_q, data_d;
    logic                   glitch_inc;
    logic [7:0]             glitch_count_q, glitch_count_d;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        glitch_inc = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                state_d = sync_q ? CONFIRM_HIGH : STABLE_LOW;
                cnt_d   = sync_q ? CNT_ONE : '0;
            end
            CONFIRM_HIGH: begin
                if (cnt_q >= CNT_LIMIT) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    data_d  = 1'b0;
                end else if (!sync_q) begin
                    state_d    = STABLE_LOW;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    data_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                state_d = sync_q ? STABLE_HIGH : CONFIRM_LOW;
                cnt_d   = sync_q ? '0 : CNT_ONE;
            end
            CONFIRM_LOW: begin
                if (cnt_q >= CNT_LIMIT) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    data_d  = 1'b0;
                end else if (sync_q) begin
                    state_d    = STABLE_HIGH;
                    cnt_d      = '0;
                    glitch_inc = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    data_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                data_d  = 1'b0;
            end
        endcase
        glitch_count_d = (glitch_inc && (glitch_count_q != 8'hFF)) ? glitch_count_q + 8'd1
                                                                    : glitch_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= STABLE_LOW;
            cnt_q          <= '0;
            data_q         <= 1'b0;
            glitch_count_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_q         <= data_d;
            glitch_count_q <= glitch_count_d;
        end
    end

    assign data_out     = data_q;
    assign glitch_count = glitch_count_q;

`ifdef ALTERA_DEBOUNCE_EDGE_EN
    logic rise_q, fall_q;

    // Pulses come only from accept transitions; safe recovery never produces one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (state_q == CONFIRM_HIGH) && sync_q && (cnt_q == CNT_LAST);
            fall_q <= (state_q == CONFIRM_LOW) && !sync_q && (cnt_q == CNT_LAST);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_altera_input_debouncer.sv
// Directed bench for altera_input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Pulse expectations apply only when ALTERA_DEBOUNCE_EDGE_EN is defined.
module tb_altera_input_debouncer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_WIDTH       = 3;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_in;
    logic       data_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    int n_vec = 0;
    int n_err = 0;
    int seen_high = 0;

    typedef struct {
        logic       raw;
        logic       d;
        logic       r;
        logic       f;
        logic [7:0] g;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    altera_input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in),
        .data_out    (data_out),
`ifdef ALTERA_DEBOUNCE_EDGE_EN
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
`endif
        .glitch_count(glitch_count)
    );

`ifndef ALTERA_DEBOUNCE_EDGE_EN
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

    task automatic check(input string name, input logic d, input logic r, input logic f,
                         input logic [7:0] g);
        logic [10:0] got, want;
        got  = {data_out, rise_pulse, fall_pulse, glitch_count};
        want = {d, r, f, g};
`ifndef ALTERA_DEBOUNCE_EDGE_EN
        want[9:8] = 2'b00;
`endif
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got data=%b rise=%b fall=%b glitch=%0d, want data=%b rise=%b fall=%b glitch=%0d",
                     name, got[10], got[9], got[8], got[7:0], want[10], want[9], want[8], want[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic rst_v, input logic raw_v);
        @(negedge clk);
        reset  = rst_v;
        raw_in = raw_v;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic raw, input logic d, input logic r, input logic f,
                       input logic [7:0] g);
        vec_t v;
        v.raw = raw;
        v.d   = d;
        v.r   = r;
        v.f   = f;
        v.g   = g;
        repeat (n) vecs.push_back(v);
    endtask

    // Three synchronized cycles high, then back low long enough to settle in STABLE_LOW.
    task automatic run_glitch();
        for (int k = 0; k < 7; k++) begin
            step(1'b0, (k < 3) ? H : L);
            if (data_out) seen_high = 1;
        end
    endtask

    initial begin
        // Row n sets raw_in before edge n; expectations hold just after that edge.
        add(5, H, L, L, L, 8'd0);   // capture at edge 0, confirm from edge 2
        add(1, H, H, H, L, 8'd0);   // accept at edge 5
        add(2, H, H, L, L, 8'd0);
        add(5, L, H, L, L, 8'd0);   // fall captured at edge 8
        add(1, L, L, L, H, 8'd0);   // accept at edge 13
        add(1, L, L, L, L, 8'd0);
        add(3, H, L, L, L, 8'd0);   // three-cycle high excursion
        add(2, L, L, L, L, 8'd0);
        add(2, L, L, L, L, 8'd1);   // rejected at edge 20
        add(5, H, L, L, L, 8'd1);
        add(1, H, H, H, L, 8'd1);   // accept at edge 27
        add(1, H, H, L, L, 8'd1);
        add(2, L, H, L, L, 8'd1);   // two-cycle low excursion
        add(2, H, H, L, L, 8'd1);
        add(2, H, H, L, L, 8'd2);   // rejected at edge 33

        // Power-on reset, raw_in toggling underneath.
        reset  = 1'b1;
        raw_in = 1'b0;
        #2;
        check("reset_initial", L, L, L, 8'd0);
        repeat (3) begin
            @(negedge clk);
            raw_in = ~raw_in;
        end
        @(posedge clk);
        #1;
        check("reset_hold", L, L, L, 8'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("idle_low", L, L, L, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].raw);
            check($sformatf("vec%0d", i), vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].g);
        end

        // Asynchronous reset between edges while data_out=1 and glitch_count=2.
        @(posedge clk);
        #3;
        raw_in = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("reset_async", L, L, L, 8'd0);
        repeat (2) begin
            @(negedge clk);
            raw_in = ~raw_in;
            @(posedge clk);
            #1;
        end
        check("reset_async_held", L, L, L, 8'd0);

        // Illegal state code while STABLE_HIGH.
        repeat (8) step(1'b0, 1'b1);
        check("pre_illegal_high", H, L, L, 8'd0);
        @(negedge clk);
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        check_int("forced_state", int'(dut.state_q), 6);
        @(posedge clk);
        #1;
        check("illegal_state_out", L, L, L, 8'd0);
        check_int("illegal_state_next", int'(dut.state_q), 0);

        // Out-of-range counter while CONFIRM_HIGH.
        step(1'b0, 1'b1);
        check_int("confirm_high_entered", int'(dut.state_q), 1);
        @(negedge clk);
        force dut.cnt_q = 3'd7;
        #1;
        release dut.cnt_q;
        @(posedge clk);
        #1;
        check("illegal_cnt_out", L, L, L, 8'd0);
        check_int("illegal_cnt_state", int'(dut.state_q), 0);
        check_int("illegal_cnt_cnt", int'(dut.cnt_q), 0);

        // Reset in the middle of a confirmation, raw_in held high throughout.
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        check_int("mid_confirm_state", int'(dut.state_q), 1);
        check_int("mid_confirm_cnt", int'(dut.cnt_q), 2);
        #3;
        reset = 1'b1;
        #1;
        check("reset_mid_confirm", L, L, L, 8'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_mid_confirm_hold", L, L, L, 8'd0);
        end
        for (int e = 0; e < 7; e++) begin
            step(1'b0, 1'b1);
            check($sformatf("post_reset_edge%0d", e), e >= 5, e == 5, L, 8'd0);
        end

        // Glitch counting and saturation.
        step(1'b1, 1'b0);
        run_glitch();
        check("first_glitch", L, L, L, 8'd1);
        repeat (299) run_glitch();
        check("glitch_saturate", L, L, L, 8'd255);
        check_int("glitch_never_high", seen_high, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
